mem_ctrl: RTL and testbench

Memory controller between the 8-bit unified RAM port and its two requesters: instruction fetch (word reads) and the load/store buffer (1/2/4-byte loads and stores). It arbitrates the single RAM port, sequences multi-byte accesses one byte per cycle, stalls IO writes on `io_buffer_full`, and returns assembled data with a one-cycle success pulse. It sits between the IFetch/LSB units and the top-level RAM/IO interface.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_req_arb.sv | 47 ++++
 rtl/mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared tags, size encodings, FSM types and IO-region helper for mem_ctrl
package mem_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic LOAD  = 1'b0;
    localparam logic STORE = 1'b1;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    function automatic logic in_io_region(input logic [31:0] addr, input logic [1:0] io_hi);
        return addr[17:16] == io_hi;
    endfunction

endpackage

// File: rtl/mem_req_arb.sv
// rtl/mem_req_arb.sv - RAM port grant selection; MEM_CTRL_RR_ARB_EN selects round-robin, else LSB-first
module mem_req_arb
    import mem_ctrl_pkg::*;
(
`ifdef MEM_CTRL_RR_ARB_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   rdy,
    input  logic   accept,
`endif
    input  logic   if_req,
    input  logic   lsb_req,
    output logic   grant_valid,
    output owner_e grant_owner
);

    assign grant_valid = if_req | lsb_req;

`ifdef MEM_CTRL_RR_ARB_EN
    owner_e last_q;
    owner_e last_d;

    // On a tie the owner served last time yields.
    always_comb begin
        if (lsb_req && (!if_req || last_q == OWN_IF)) begin
            grant_owner = OWN_LSB;
        end else begin
            grant_owner = OWN_IF;
        end
        last_d = last_q;
        if (accept && grant_valid) begin
            last_d = grant_owner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_IF;
        end else if (rdy) begin
            last_q <= last_d;
        end
    end
`else
    assign grant_owner = lsb_req ? OWN_LSB : OWN_IF;
`endif

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port controller for IFetch and LSB; MEM_CTRL_RR_ARB_EN enables round-robin grant
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_flag,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_success,
    output logic [31:0] if_data,
    input  logic        lsb_enable,
    input  logic        lsb_wr_tag,
    input  logic [2:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_success,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        wr_q, wr_d;
    logic        if_success_q, if_success_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_success_q, lsb_success_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        grant_valid;
    owner_e      grant_owner;
    logic        io_stall;
    logic        jump_kill;
    logic        grant_store;
    logic [2:0]  idx_nxt;
    logic [1:0]  cap_byte;
    logic [31:0] wshift;

    mem_req_arb u_arb (
`ifdef MEM_CTRL_RR_ARB_EN
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .accept      (state_q == ST_IDLE),
`endif
        .if_req      (if_enable & ~jump_flag),
        .lsb_req     (lsb_enable),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The IO write queue is checked live so a full queue blocks the strobe this very cycle.
    assign io_stall  = wr_q && in_io_region(mem_a_q, IO_BASE_HI) && io_buffer_full;
    assign jump_kill = jump_flag && (owner_q == OWN_IF);

    assign mem_wr      = wr_q & rdy & ~io_stall;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign if_success  = if_success_q;
    assign if_data     = if_data_q;
    assign lsb_success = lsb_success_q;
    assign lsb_rdata   = lsb_rdata_q;

    assign grant_store = (grant_owner == OWN_LSB) && (lsb_wr_tag == STORE);
    assign idx_nxt     = idx_q + 3'd1;
    assign cap_byte    = idx_q[1:0] - 2'd1;
    assign wshift      = wdata_q >> {idx_nxt, 3'b000};

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        idx_d         = idx_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        buf_d         = buf_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        wr_d          = wr_q;
        if_success_d  = FALSE;
        if_data_d     = if_data_q;
        lsb_success_d = FALSE;
        lsb_rdata_d   = lsb_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d    = grant_owner;
                    addr_d     = (grant_owner == OWN_LSB) ? lsb_addr : if_addr;
                    size_d     = (grant_owner == OWN_LSB) ? lsb_size : SIZE_W;
                    wdata_d    = lsb_wdata;
                    buf_d      = 32'd0;
                    idx_d      = 3'd0;
                    mem_a_d    = (grant_owner == OWN_LSB) ? lsb_addr : if_addr;
                    mem_dout_d = grant_store ? lsb_wdata[7:0] : 8'd0;
                    wr_d       = grant_store;
                    state_d    = grant_store ? ST_WRITE : ST_READ;
                end
            end

            ST_READ: begin
                if (jump_kill) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    mem_a_d = 32'd0;
                end else begin
                    // mem_din carries the byte addressed one cycle ago.
                    if (idx_q != 3'd0) begin
                        case (cap_byte)
                            2'd0:    buf_d[7:0]   = mem_din;
                            2'd1:    buf_d[15:8]  = mem_din;
                            2'd2:    buf_d[23:16] = mem_din;
                            default: buf_d[31:24] = mem_din;
                        endcase
                    end
                    if (idx_q == size_q) begin
                        state_d = ST_DONE;
                        mem_a_d = 32'd0;
                        if (owner_q == OWN_IF) begin
                            if_success_d = TRUE;
                            if_data_d    = buf_d;
                        end else begin
                            lsb_success_d = TRUE;
                            lsb_rdata_d   = buf_d;
                        end
                    end else begin
                        idx_d   = idx_nxt;
                        mem_a_d = (idx_nxt == size_q) ? 32'd0 : addr_q + {29'd0, idx_nxt};
                    end
                end
            end

            ST_WRITE: begin
                if (idx_q == size_q) begin
                    state_d = ST_DONE;
                end else if (!io_stall) begin
                    idx_d = idx_nxt;
                    if (idx_nxt == size_q) begin
                        wr_d          = FALSE;
                        mem_a_d       = 32'd0;
                        mem_dout_d    = 8'd0;
                        lsb_success_d = TRUE;
                    end else begin
                        mem_a_d    = addr_q + {29'd0, idx_nxt};
                        mem_dout_d = wshift[7:0];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            idx_q         <= 3'd0;
            size_q        <= 3'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            buf_q         <= 32'd0;
            mem_a_q       <= 32'd0;
            mem_dout_q    <= 8'd0;
            wr_q          <= 1'b0;
            if_success_q  <= 1'b0;
            if_data_q     <= 32'd0;
            lsb_success_q <= 1'b0;
            lsb_rdata_q   <= 32'd0;
        end else if (rdy) begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            idx_q         <= idx_d;
            size_q        <= size_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            buf_q         <= buf_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            wr_q          <= wr_d;
            if_success_q  <= if_success_d;
            if_data_q     <= if_data_d;
            lsb_success_q <= lsb_success_d;
            lsb_rdata_q   <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_flag;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_success;
    logic [31:0] if_data;
    logic        lsb_enable;
    logic        lsb_wr_tag;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_success;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jump_flag      (jump_flag),
        .if_enable      (if_enable),
        .if_addr        (if_addr),
        .if_success     (if_success),
        .if_data        (if_data),
        .lsb_enable     (lsb_enable),
        .lsb_wr_tag     (lsb_wr_tag),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_success    (lsb_success),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        lsb_enable = 1'b0; lsb_wr_tag = 1'b0; lsb_size = 3'b001; lsb_addr = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ram[32'h40] = 8'h78; ram[32'h41] = 8'h56; ram[32'h42] = 8'h34; ram[32'h43] = 8'h12;
        ram[32'h30000] = 8'hA5;

        tick(); tick();
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_success", {30'd0, if_success, lsb_success}, 32'd0);
        check("rst_data", if_data | lsb_rdata, 32'd0);
        rst = 1'b1;
        tick();

        // IF word read of 0x1000
        if_enable = 1'b1; if_addr = 32'h1000;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("if_addr%0d", i), mem_a, 32'h1000 + i);
            check($sformatf("if_rd_wr%0d", i), {31'd0, mem_wr}, 32'd0);
            tick();
        end
        check("if_no_early_success", {31'd0, if_success}, 32'd0);
        tick();
        check("if_success_g5", {31'd0, if_success}, 32'd1);
        check("if_data", if_data, 32'h0000_0513);
        if_enable = 1'b0;
        tick();
        check("if_success_pulse", {31'd0, if_success}, 32'd0);
        check("if_data_stable", if_data, 32'h0000_0513);
        tick();

        // LSB SH 0xBEEF to 0x2002, with an rdy=0 glitch proving mem_wr is gated
        lsb_enable = 1'b1; lsb_wr_tag = 1'b1; lsb_size = 3'b010; lsb_addr = 32'h2002; lsb_wdata = 32'h0000_BEEF;
        tick();
        check("sh_wr0", {31'd0, mem_wr}, 32'd1);
        check("sh_a0", mem_a, 32'h2002);
        check("sh_d0", {24'd0, mem_dout}, 32'hEF);
        rdy = 1'b0; #1;
        check("rdy_low_wr", {31'd0, mem_wr}, 32'd0);
        rdy = 1'b1;
        tick();
        check("sh_wr1", {31'd0, mem_wr}, 32'd1);
        check("sh_a1", mem_a, 32'h2003);
        check("sh_d1", {24'd0, mem_dout}, 32'hBE);
        check("sh_no_early_success", {31'd0, lsb_success}, 32'd0);
        tick();
        check("sh_success_g2", {31'd0, lsb_success}, 32'd1);
        check("sh_wr_off", {31'd0, mem_wr}, 32'd0);
        check("sh_ram", {16'd0, ram_rd(32'h2003), ram_rd(32'h2002)}, 32'h0000_BEEF);
        lsb_enable = 1'b0;
        tick(); tick();

        // Simultaneous IF and LSB LB of 0x30000
        if_enable = 1'b1; if_addr = 32'h1000;
        lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_size = 3'b001; lsb_addr = 32'h30000;
        tick();
        check("lb_first_addr", mem_a, 32'h30000);
        tick();
        check("lb_single_addr", mem_a, 32'd0);
        tick();
        check("lb_success", {31'd0, lsb_success}, 32'd1);
        check("lb_rdata", lsb_rdata, 32'h0000_00A5);
        lsb_enable = 1'b0;
        tick();
        check("done_no_grant", mem_a, 32'd0);
        tick();
        check("if_after_lb", mem_a, 32'h1000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = if_success;
        end
        check("if_after_lb_success", {31'd0, seen}, 32'd1);
        check("if_after_lb_data", if_data, 32'h0000_0513);
        if_enable = 1'b0;
        tick(); tick();

        // IO SB to 0x30004 blocked by io_buffer_full for three cycles
        io_buffer_full = 1'b1;
        lsb_enable = 1'b1; lsb_wr_tag = 1'b1; lsb_size = 3'b001; lsb_addr = 32'h30004; lsb_wdata = 32'h0000_005A;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("io_stall%0d", i), {31'd0, mem_wr}, 32'd0);
            check($sformatf("io_stall_a%0d", i), mem_a, 32'h30004);
            tick();
        end
        io_buffer_full = 1'b0; #1;
        check("io_write", {31'd0, mem_wr}, 32'd1);
        check("io_dout", {24'd0, mem_dout}, 32'h5A);
        check("io_no_early_success", {31'd0, lsb_success}, 32'd0);
        tick();
        check("io_success", {31'd0, lsb_success}, 32'd1);
        check("io_ram", {24'd0, ram_rd(32'h30004)}, 32'h5A);
        lsb_enable = 1'b0;
        tick(); tick();

        // jump_flag at G+2 of an IF read; pending LSB LW then completes
        if_enable = 1'b1; if_addr = 32'h1000;
        tick(); tick(); tick();
        jump_flag = 1'b1;
        lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_size = 3'b100; lsb_addr = 32'h40;
        tick();
        jump_flag = 1'b0; if_enable = 1'b0;
        check("jump_idle_a", mem_a, 32'd0);
        check("jump_no_success", {31'd0, if_success}, 32'd0);
        tick();
        check("lw_after_jump_addr", mem_a, 32'h40);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = lsb_success;
            if (if_success) check("jump_late_if_success", 32'd1, 32'd0);
        end
        check("lw_success", {31'd0, seen}, 32'd1);
        check("lw_rdata", lsb_rdata, 32'h1234_5678);
        lsb_enable = 1'b0;
        tick(); tick();

        // Reset asserted mid-write
        lsb_enable = 1'b1; lsb_wr_tag = 1'b1; lsb_size = 3'b100; lsb_addr = 32'h50; lsb_wdata = 32'hDEAD_BEEF;
        tick(); tick();
        check("sw_mid_wr", {31'd0, mem_wr}, 32'd1);
        check("sw_mid_a", mem_a, 32'h51);
        rst = 1'b0; #1;
        check("arst_wr", {31'd0, mem_wr}, 32'd0);
        check("arst_a", mem_a, 32'd0);
        check("arst_dout", {24'd0, mem_dout}, 32'd0);
        check("arst_data", if_data | lsb_rdata, 32'd0);
        lsb_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        lsb_enable = 1'b1; lsb_wr_tag = 1'b0; lsb_size = 3'b001; lsb_addr = 32'h30000;
        tick();
        check("post_rst_addr", mem_a, 32'h30000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = lsb_success;
        end
        check("post_rst_success", {31'd0, seen}, 32'd1);
        check("post_rst_rdata", lsb_rdata, 32'h0000_00A5);
        lsb_enable = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
